// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and display bus of the sequential binary-to-BCD converter.
// The master drives the request; the slave (converter) returns status and digits.
interface bin_to_bcd_seq_if;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [3:0]  dig4;

    modport master (
        output start, bin,
        input  busy, done, ovf, dig1, dig2, dig3, dig4
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, dig1, dig2, dig3, dig4
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter using shift-and-add-3.
// Displayed digits only change on the single LOAD edge that also pulses done.
module bin_to_bcd_seq #(
    parameter bit SATURATE = 1'b1
) (
    input logic           clk,
    input logic           clr,
    bin_to_bcd_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [13:0] r_operand;
    logic [15:0] r_bcd;
    logic [3:0]  r_count;
    logic        r_ovfPending;

    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic [3:0]  r_dig1;
    logic [3:0]  r_dig2;
    logic [3:0]  r_dig3;
    logic [3:0]  r_dig4;

    logic        w_overRange;
    logic [13:0] w_operandIn;
    logic [15:0] w_bcdAdj;

    // The 14th shift happens on the edge where the counter still reads 13.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = SHIFT;
            SHIFT:   if (r_count == 4'd13) w_nextState = LOAD;
            LOAD:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_overRange = (bus.bin > 14'd9999);
        w_operandIn = bus.bin;
        if (w_overRange) begin
            w_operandIn = SATURATE ? 14'd9999 : 14'd0;
        end
        w_bcdAdj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_operand    <= '0;
            r_bcd        <= '0;
            r_count      <= '0;
            r_ovfPending <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_dig1       <= '0;
            r_dig2       <= '0;
            r_dig3       <= '0;
            r_dig4       <= '0;
        end else begin
            r_state <= w_nextState;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_operand    <= w_operandIn;
                        r_ovfPending <= w_overRange;
                        r_bcd        <= '0;
                        r_count      <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Operand MSB feeds the BCD LSB; the adjusted top bit never carries out for values <= 9999.
                    {r_bcd, r_operand} <= {w_bcdAdj[14:0], r_operand, 1'b0};
                    r_count            <= r_count + 4'd1;
                end
                LOAD: begin
                    r_dig1 <= r_bcd[15:12];
                    r_dig2 <= r_bcd[11:8];
                    r_dig3 <= r_bcd[7:4];
                    r_dig4 <= r_bcd[3:0];
                    r_ovf  <= r_ovfPending;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.dig1 = r_dig1;
    assign bus.dig2 = r_dig2;
    assign bus.dig3 = r_dig3;
    assign bus.dig4 = r_dig4;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: one saturating and one zeroing converter share the same stimulus
// and are compared against a decimal-arithmetic model of the expected display.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [13:0] bin;

    int checks   = 0;
    int failures = 0;

    logic        monitorOn = 1'b0;
    logic        clrAtEdge = 1'b0;
    logic [15:0] prevSat;
    logic [15:0] prevZero;

    bin_to_bcd_seq_if ifSat ();
    bin_to_bcd_seq_if ifZero ();

    assign ifSat.start  = start;
    assign ifSat.bin    = bin;
    assign ifZero.start = start;
    assign ifZero.bin   = bin;

    bin_to_bcd_seq #(.SATURATE(1'b1)) dutSat (
        .clk (clk),
        .clr (clr),
        .bus (ifSat.slave)
    );

    bin_to_bcd_seq #(.SATURATE(1'b0)) dutZero (
        .clk (clk),
        .clr (clr),
        .bus (ifZero.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display value: in-range values pass, out-of-range values follow the policy.
    function automatic int modelValue(input int value, input bit saturate);
        if (value > 9999) return saturate ? 9999 : 0;
        return value;
    endfunction

    function automatic logic [15:0] modelDigits(input int value);
        int d;
        d = ((value / 1000) % 10) * 4096 + ((value / 100) % 10) * 256
          + ((value / 10) % 10) * 16 + (value % 10);
        return 16'(d);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startVal, input int binVal);
        start = startVal;
        bin   = 14'(binVal);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBoth(input string tag, input int value);
        checkOutput({tag, "DigSat"},  {ifSat.dig1, ifSat.dig2, ifSat.dig3, ifSat.dig4},
                    32'(modelDigits(modelValue(value, 1'b1))));
        checkOutput({tag, "DigZero"}, {ifZero.dig1, ifZero.dig2, ifZero.dig3, ifZero.dig4},
                    32'(modelDigits(modelValue(value, 1'b0))));
        checkOutput({tag, "OvfSat"},  32'(ifSat.ovf),  32'(value > 9999));
        checkOutput({tag, "OvfZero"}, 32'(ifZero.ovf), 32'(value > 9999));
    endtask

    // Accept value at E0, optionally fire a stray start at edge midK, expect results right after E15.
    task automatic convert(input string tag, input int value, input int midK, input int midBin);
        applyStimulus(1'b1, value);
        step();
        applyStimulus(1'b0, value);
        for (int k = 0; k < 15; k++) begin
            checkOutput({tag, "Busy"}, {31'b0, ifSat.busy & ifZero.busy}, 32'd1);
            checkOutput({tag, "DoneEarly"}, {31'b0, ifSat.done | ifZero.done}, 32'd0);
            if (k == midK - 1) applyStimulus(1'b1, midBin);
            step();
            if (k == midK - 1) applyStimulus(1'b0, midBin);
        end
        checkOutput({tag, "Done"}, {31'b0, ifSat.done & ifZero.done}, 32'd1);
        checkOutput({tag, "BusyEnd"}, {31'b0, ifSat.busy | ifZero.busy}, 32'd0);
        checkBoth(tag, value);
    endtask

    // Digits and ovf may only move on a done cycle or right after a clear.
    always @(negedge clk) begin
        if (monitorOn) begin
            checks++;
            assert ((({ifSat.dig1, ifSat.dig2, ifSat.dig3, ifSat.dig4} === prevSat) &&
                     ({ifZero.dig1, ifZero.dig2, ifZero.dig3, ifZero.dig4} === prevZero)) ||
                    (ifSat.done && ifZero.done) || clrAtEdge) else begin
                failures++;
                $error("[TB] FAIL digitStability observed=%h/%h expected=%h/%h",
                       {ifSat.dig1, ifSat.dig2, ifSat.dig3, ifSat.dig4},
                       {ifZero.dig1, ifZero.dig2, ifZero.dig3, ifZero.dig4}, prevSat, prevZero);
            end
        end
        prevSat  = {ifSat.dig1, ifSat.dig2, ifSat.dig3, ifSat.dig4};
        prevZero = {ifZero.dig1, ifZero.dig2, ifZero.dig3, ifZero.dig4};
    end

    always @(posedge clk) clrAtEdge = clr;

    initial begin
        int value;
        clr = 1'b1;
        applyStimulus(1'b0, 0);
        step();
        step();
        checkOutput("resetBusy", {31'b0, ifSat.busy | ifZero.busy}, 32'd0);
        checkOutput("resetDone", {31'b0, ifSat.done | ifZero.done}, 32'd0);
        checkBoth("reset", 0);
        clr = 1'b0;
        monitorOn = 1'b1;

        convert("c1234", 1234, 0, 0);
        convert("c9999", 9999, 0, 0);
        convert("c0", 0, 0, 0);
        step();
        checkOutput("idleDone", {31'b0, ifSat.done | ifZero.done}, 32'd0);
        checkOutput("idleBusy", {31'b0, ifSat.busy | ifZero.busy}, 32'd0);

        convert("c10000", 10000, 0, 0);
        convert("c16383", 16383, 0, 0);

        convert("c42", 42, 5, 777);
        step();
        checkOutput("c42Single", {31'b0, ifSat.done | ifZero.done}, 32'd0);
        checkBoth("c42Hold", 42);

        convert("pre1234", 1234, 0, 0);
        applyStimulus(1'b1, 5678);
        step();
        applyStimulus(1'b0, 5678);
        for (int k = 1; k < 7; k++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("abortBusy", {31'b0, ifSat.busy | ifZero.busy}, 32'd0);
        checkOutput("abortDone", {31'b0, ifSat.done | ifZero.done}, 32'd0);
        checkBoth("abort", 0);
        convert("c5678", 5678, 0, 0);

        for (int n = 0; n < 1000; n++) begin
            value = int'($urandom_range(0, 16383));
            convert("rand", value, 0, 0);
            checkOutput("randRange",
                        {31'b0, (ifSat.dig1 <= 9) && (ifSat.dig2 <= 9) && (ifSat.dig3 <= 9) &&
                                (ifSat.dig4 <= 9) && (ifZero.dig1 <= 9) && (ifZero.dig2 <= 9) &&
                                (ifZero.dig3 <= 9) && (ifZero.dig4 <= 9)}, 32'd1);
        end

        step();
        monitorOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: SATURATE, default 1, selects the out-of-range policy (1 = clamp to 9999; 0 = force 0000).
REQ-002 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: clr  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  conversion request; sampled only on edges where the FSM is in IDLE.
REQ-006 Port: bin  input  14  unsigned binary value; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while a conversion is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking the update of dig1..dig4.
REQ-009 Port: ovf  output  1  high when the last accepted bin exceeded 9999; updated together with the digits.
REQ-010 Port: dig1  output  4  BCD thousands digit (leftmost display).
REQ-011 Port: dig2  output  4  BCD hundreds digit.
REQ-012 Port: dig3  output  4  BCD tens digit.
REQ-013 Port: dig4  output  4  BCD units digit (rightmost display).

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and LOAD only; every output SHALL be registered.
REQ-015 IDLE: on an edge with start=1, capture bin, apply the policy in REQ-016, clear the 16-bit BCD accumulator, reset the 4-bit shift counter to 0, set busy=1 and enter SHIFT.
REQ-016 Range rule: if bin > 9999, the captured operand is 9999 when SATURATE=1 or 0 when SATURATE=0; a pending ovf flag is set to 1, otherwise to 0.
REQ-017 SHIFT, on each edge: add 3 to every BCD nibble >= 5, then shift {BCD, operand} left by one bit, with the operand MSB entering the BCD LSB, and increment the counter.
REQ-018 SHIFT SHALL run exactly 14 edges; the edge that performs the 14th shift SHALL move the FSM to LOAD.
REQ-019 LOAD, on the next edge: load dig1..dig4 from the accumulator, load ovf from the pending flag, set done=1, set busy=0 and return to IDLE.
REQ-020 Latency: if start is accepted at edge E0, busy SHALL be high from E0 to E15 and the new digits plus done SHALL appear at E15 (15 cycles).
REQ-021 done SHALL be high for exactly one cycle per completed conversion and low at all other times.
REQ-022 start is ignored in SHIFT and LOAD: no restart, no queuing and no change to the operand.
REQ-023 start may be asserted on the edge immediately after done rises (FSM in IDLE), giving back-to-back conversions every 16 cycles.
REQ-024 dig1..dig4 and ovf SHALL hold their last loaded values at all times except the LOAD edge, so a downstream display never shows intermediate values.
REQ-025 Each output digit SHALL be in the range 0..9.
REQ-026 An input of bin=0 SHALL complete normally and produce 0000.

Reset
REQ-027 On an edge with clr=1: FSM to IDLE; busy=0, done=0, ovf=0, dig1..dig4=0; accumulator, operand and counter cleared.
REQ-028 clr SHALL take priority over start and over any in-progress conversion.
REQ-029 A reset during SHIFT or LOAD aborts the conversion with no done pulse; a start on the first edge after clr deasserts SHALL be accepted.

Verification
REQ-030 Reset, then bin=1234 with start pulsed at E0 -> busy high E0..E15, done=1 only in the cycle after E15, dig1..dig4=1,2,3,4, ovf=0.
REQ-031 bin=9999, then bin=0 back-to-back (second start on the edge after done) -> 9,9,9,9 with ovf=0, then 0,0,0,0 with ovf=0, done pulses exactly 16 cycles apart.
REQ-032 bin=10000 with SATURATE=1 -> 9,9,9,9 and ovf=1; bin=16383 with SATURATE=0 -> 0,0,0,0 and ovf=1.
REQ-033 Accept bin=42, then at E5 drive start=1 with bin=777 -> ignored; result 0,0,4,2 at E15 with a single done pulse.
REQ-034 Accept bin=5678 with prior outputs at 1,2,3,4, assert clr at E7 -> all outputs 0 at E7, no done; a new start with bin=5678 at E8 -> 5,6,7,8 at E23.
REQ-035 Random sweep of 1000 values in 0..16383 -> digits match the decimal value (or the REQ-016 policy), each digit <= 9, and digits never change outside a done cycle.
